// File: rtl/gpr_mt_regfile_pkg.sv
// Shared definitions for the multi-threaded GPR file: default geometry,
// the value/id types at default sizing, and the clear-sequencer state encoding.
package rfPhoenixPkg;

   localparam int NTHREADS_DEF = 4;
   localparam int NREGS_DEF    = 64;
   localparam int WID_DEF      = 128;
   localparam int NLANES_DEF   = 4;
   localparam int TW_DEF       = $clog2(NTHREADS_DEF);
   localparam int RW_DEF       = $clog2(NREGS_DEF);
   localparam int LW_DEF       = WID_DEF / NLANES_DEF;

   typedef logic [TW_DEF-1:0]  tid_t;
   typedef logic [RW_DEF-1:0]  regnum_t;
   typedef logic [WID_DEF-1:0] value_t;

   typedef logic [1:0] clr_state_t;
   localparam clr_state_t ST_INIT_ALL   = 2'd0;
   localparam clr_state_t ST_IDLE       = 2'd1;
   localparam clr_state_t ST_CLR_THREAD = 2'd2;

endpackage

// File: rtl/gpr_mt_regfile_clr_seq.sv
// Clear sequencer: zeroes the whole file after reset, or one thread's
// context on request, through an internal zero-write port.
//
// state         | meaning
// ST_INIT_ALL   | sweeping every {thread,reg} after reset
// ST_IDLE       | normal operation, accepts clr_req
// ST_CLR_THREAD | sweeping the latched thread's registers
module gpr_clr_seq import rfPhoenixPkg::*; #(
   parameter int NTHREADS = 4,
   parameter int NREGS    = 64
) (
   input  logic                                      clk,
   input  logic                                      rst,
   input  logic                                      clr_req,
   input  logic [$clog2(NTHREADS)-1:0]               clr_thread,
   output logic                                      busy,
   output logic                                      clr_done,
   output logic                                      zwe,
   output logic [$clog2(NTHREADS)+$clog2(NREGS)-1:0] zaddr
);

   localparam int TW = $clog2(NTHREADS);
   localparam int RW = $clog2(NREGS);
   localparam int AW = TW + RW;
   localparam logic [AW-1:0] LAST_ALL = '1;
   localparam logic [RW-1:0] LAST_REG = '1;

   clr_state_t      state;
   logic [AW-1:0]   cnt;
   logic [TW-1:0]   thr;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= ST_INIT_ALL;
         cnt      <= '0;
         thr      <= '0;
         busy     <= 1'b1;
         clr_done <= 1'b0;
      end else begin
         clr_done <= 1'b0;
         case (state)
            ST_INIT_ALL: begin
               if (cnt == LAST_ALL) begin
                  state    <= ST_IDLE;
                  busy     <= 1'b0;
                  clr_done <= 1'b1;
                  cnt      <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_IDLE: begin
               if (clr_req) begin
                  thr   <= clr_thread;
                  busy  <= 1'b1;
                  cnt   <= '0;
                  state <= ST_CLR_THREAD;
               end
            end
            ST_CLR_THREAD: begin
               if (cnt[RW-1:0] == LAST_REG) begin
                  state    <= ST_IDLE;
                  busy     <= 1'b0;
                  clr_done <= 1'b1;
                  cnt      <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   assign zwe   = busy;
   assign zaddr = (state == ST_CLR_THREAD) ? {thr, cnt[RW-1:0]} : cnt;

endmodule

// File: rtl/gpr_mt_regfile.sv
// Multi-threaded GPR file: one lane-maskable write port, NRD registered read
// ports with write-through forwarding, and a hardware clear sequencer.
module gpr_mt_regfile import rfPhoenixPkg::*; #(
   parameter int NTHREADS    = 4,
   parameter int NREGS       = 64,
   parameter int WID         = 128,
   parameter int NLANES      = 4,
   parameter int NRD         = 5,
   parameter int ZERO_BYPASS = 1
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              ce,
   input  logic [NLANES-1:0]                 wr,
   input  logic [$clog2(NTHREADS)-1:0]       wthread,
   input  logic [$clog2(NREGS)-1:0]          wa,
   input  logic [WID-1:0]                    i,
   input  logic [$clog2(NTHREADS)-1:0]       rthread,
   input  logic [NRD*$clog2(NREGS)-1:0]      ra,
   output logic [NRD*WID-1:0]                o,
   input  logic                              clr_req,
   input  logic [$clog2(NTHREADS)-1:0]       clr_thread,
   output logic                              busy,
   output logic                              clr_done
);

   localparam int TW = $clog2(NTHREADS);
   localparam int RW = $clog2(NREGS);
   localparam int AW = TW + RW;
   localparam int LW = WID / NLANES;

   logic [WID-1:0] mem [NTHREADS*NREGS];
   logic           zwe;
   logic [AW-1:0]  zaddr;
   logic           wr_ok;
   logic [WID-1:0] rd [NRD];

   gpr_clr_seq #(
      .NTHREADS (NTHREADS),
      .NREGS    (NREGS)
   ) u_clr_seq (
      .clk        (clk),
      .rst        (rst),
      .clr_req    (clr_req),
      .clr_thread (clr_thread),
      .busy       (busy),
      .clr_done   (clr_done),
      .zwe        (zwe),
      .zaddr      (zaddr)
   );

   assign wr_ok = ce && !busy && (|wr);

   // Sweep writes have priority; external writes are only accepted when idle anyway.
   always_ff @(posedge clk) begin
      if (zwe) begin
         mem[zaddr] <= '0;
      end else if (wr_ok) begin
         for (int k = 0; k < NLANES; k++) begin
            if (wr[k]) mem[{wthread, wa}][k*LW +: LW] <= i[k*LW +: LW];
         end
      end
   end

   always_comb begin
      for (int p = 0; p < NRD; p++) begin
         rd[p] = mem[{rthread, ra[p*RW +: RW]}];
         for (int k = 0; k < NLANES; k++) begin
            if (wr_ok && wr[k] && (wthread == rthread) && (wa == ra[p*RW +: RW]))
               rd[p][k*LW +: LW] = i[k*LW +: LW];
         end
         if ((ZERO_BYPASS != 0) && (ra[p*RW +: RW] == '0)) rd[p] = '0;
         if (busy) rd[p] = '0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         o <= '0;
      end else if (ce) begin
         for (int p = 0; p < NRD; p++) o[p*WID +: WID] <= rd[p];
      end
   end

endmodule

// File: tb/tb_gpr_mt_regfile.sv
// Randomized and directed bench for gpr_mt_regfile against an array-based reference model.
module tb_gpr_mt_regfile;

   localparam int NT = 4, NR = 64, WID = 128, NL = 4, NRD = 5, ZB = 1;
   localparam int TW = 2, RW = 6, LW = WID / NL, NADDR = NT * NR;

   logic                 clk, rst, ce, clr_req, busy, clr_done;
   logic [NL-1:0]        wr;
   logic [TW-1:0]        wthread, rthread, clr_thread;
   logic [RW-1:0]        wa;
   logic [WID-1:0]       i;
   logic [NRD*RW-1:0]    ra;
   logic [NRD*WID-1:0]   o;

   gpr_mt_regfile #(
      .NTHREADS (NT), .NREGS (NR), .WID (WID), .NLANES (NL), .NRD (NRD), .ZERO_BYPASS (ZB)
   ) dut (
      .clk (clk), .rst (rst), .ce (ce), .wr (wr), .wthread (wthread), .wa (wa), .i (i),
      .rthread (rthread), .ra (ra), .o (o), .clr_req (clr_req), .clr_thread (clr_thread),
      .busy (busy), .clr_done (clr_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // reference model: register contents plus a pending list of sweep writes
   logic [WID-1:0] mdl [NADDR];
   logic [WID-1:0] exp_o [NRD];
   bit             m_busy, m_done;
   int             m_base, m_pos, m_len;
   int             nvec, nerr;

   task automatic chk(input string tag, input logic [WID-1:0] got, input logic [WID-1:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [WID-1:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic idle_in();
      ce = 1'b1; wr = '0; wthread = '0; wa = '0; i = '0;
      rthread = '0; ra = '0; clr_req = 1'b0; clr_thread = '0;
   endtask

   task automatic set_ra(input int a);
      for (int p = 0; p < NRD; p++) ra[p*RW +: RW] = RW'(a);
   endtask

   // Predict from current inputs, clock once, compare every output.
   task automatic cycle();
      logic [WID-1:0] e;
      int a;
      if (ce) begin
         for (int p = 0; p < NRD; p++) begin
            a = int'(ra[p*RW +: RW]);
            e = mdl[int'(rthread) * NR + a];
            if (!m_busy && (|wr) && wthread == rthread && int'(wa) == a)
               for (int k = 0; k < NL; k++) if (wr[k]) e[k*LW +: LW] = i[k*LW +: LW];
            if (m_busy || (ZB != 0 && a == 0)) e = '0;
            exp_o[p] = e;
         end
      end
      m_done = 1'b0;
      if (m_busy) begin
         mdl[m_base + m_pos] = '0;
         m_pos++;
         if (m_pos == m_len) begin
            m_busy = 1'b0;
            m_done = 1'b1;
         end
      end else begin
         if (ce && (|wr))
            for (int k = 0; k < NL; k++)
               if (wr[k]) mdl[int'(wthread) * NR + int'(wa)][k*LW +: LW] = i[k*LW +: LW];
         if (clr_req) begin
            m_busy = 1'b1;
            m_base = int'(clr_thread) * NR;
            m_pos  = 0;
            m_len  = NR;
         end
      end
      @(posedge clk);
      #1;
      chk("busy", WID'(busy), WID'(m_busy));
      chk("clr_done", WID'(clr_done), WID'(m_done));
      for (int p = 0; p < NRD; p++) chk($sformatf("o[%0d]", p), o[p*WID +: WID], exp_o[p]);
   endtask

   task automatic do_reset();
      idle_in();
      rst = 1'b0;
      m_busy = 1'b1; m_done = 1'b0; m_base = 0; m_pos = 0; m_len = NADDR;
      for (int p = 0; p < NRD; p++) exp_o[p] = '0;
      #3;
      chk("rst_busy", WID'(busy), WID'(1));
      chk("rst_done", WID'(clr_done), WID'(0));
      for (int p = 0; p < NRD; p++) chk($sformatf("rst_o[%0d]", p), o[p*WID +: WID], '0);
      rst = 1'b1;
   endtask

   // Run until the model leaves busy, with random (dropped) writes; returns cycle count.
   task automatic run_sweep(output int n);
      n = 0;
      while (m_busy && n < 400) begin
         ce = 1'($urandom); wr = NL'($urandom); wthread = TW'($urandom);
         wa = RW'($urandom); i = rnd128(); rthread = TW'($urandom); ra = NRD*RW'($urandom);
         clr_req = 1'b0;
         cycle();
         n++;
      end
      idle_in();
   endtask

   logic [WID-1:0] cval, pval;
   int n;

   initial begin
      nvec = 0; nerr = 0;
      rst = 1'b1;
      idle_in();
      @(posedge clk); #1;
      do_reset();

      // post-reset init sweep length, then everything reads zero
      run_sweep(n);
      chk("init_len", WID'(n), WID'(NADDR));
      for (int t = 0; t < NT; t++)
         for (int r = 1; r < NR; r += NRD) begin
            rthread = TW'(t);
            for (int p = 0; p < NRD; p++) ra[p*RW +: RW] = RW'((r + p) % NR == 0 ? 1 : (r + p) % NR);
            cycle();
         end

      // full write then read-back, other thread unaffected
      cval = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
      wr = 4'b1111; wthread = 2'd2; wa = 6'd5; i = cval;
      cycle();
      wr = '0; rthread = 2'd2; set_ra(5);
      cycle();
      chk("s2_t2r5", o[0 +: WID], cval);
      rthread = 2'd1;
      cycle();
      chk("s2_t1r5", o[0 +: WID], '0);

      // single-lane write
      wr = 4'b0100; wthread = 2'd2; wa = 6'd5; i = {4{32'hAAAA_AAAA}};
      cycle();
      wr = '0; rthread = 2'd2; set_ra(5);
      cycle();
      chk("s3_lane2", o[0 +: WID], {cval[127:96], 32'hAAAA_AAAA, cval[63:0]});

      // same-cycle forwarding on all ports
      pval = rnd128();
      wr = 4'b1111; wthread = 2'd0; wa = 6'd7; i = pval;
      cycle();
      wr = 4'b0011; i = {32{4'h5}}; rthread = 2'd0; set_ra(7);
      cycle();
      chk("s4_fwd", o[4*WID +: WID], {pval[127:64], {16{4'h5}}});
      wr = '0;

      // register 0 reads as zero even when written
      wr = 4'b1111; wthread = 2'd3; wa = 6'd0; i = '1;
      cycle();
      wr = '0; rthread = 2'd3; set_ra(0);
      cycle();
      chk("s5_r0", o[0 +: WID], '0);

      // ce low holds the output registers
      rthread = 2'd2; set_ra(5); cycle();
      ce = 1'b0; set_ra(0); rthread = 2'd1;
      cycle(); cycle();
      ce = 1'b1;

      // fill threads 0/1, clear thread 1
      for (int t = 0; t < 2; t++)
         for (int r = 1; r < NR; r++) begin
            wr = 4'b1111; wthread = TW'(t); wa = RW'(r); i = rnd128() | 128'h1;
            rthread = TW'($urandom); ra = NRD*RW'($urandom);
            cycle();
         end
      idle_in();
      clr_req = 1'b1; clr_thread = 2'd1;
      cycle();
      run_sweep(n);
      chk("clr_len", WID'(n), WID'(NR));
      for (int t = 0; t < 2; t++)
         for (int r = 0; r < NR; r += NRD) begin
            rthread = TW'(t);
            for (int p = 0; p < NRD; p++) ra[p*RW +: RW] = RW'((r + p) % NR);
            cycle();
         end

      // reset in the middle of a thread sweep restarts the full init
      idle_in();
      clr_req = 1'b1; clr_thread = 2'd1;
      cycle();
      clr_req = 1'b0;
      for (int c = 0; c < 30; c++) cycle();
      do_reset();
      run_sweep(n);
      chk("reinit_len", WID'(n), WID'(NADDR));

      // random traffic with clustered addresses to exercise forwarding
      for (int c = 0; c < 3000; c++) begin
         ce = ($urandom_range(0, 9) != 0);
         wr = ($urandom_range(0, 2) == 0) ? '0 : NL'($urandom);
         wthread = TW'($urandom); rthread = ($urandom_range(0, 1) == 0) ? wthread : TW'($urandom);
         wa = ($urandom_range(0, 1) == 0) ? RW'($urandom_range(0, 3)) : RW'($urandom);
         for (int p = 0; p < NRD; p++)
            ra[p*RW +: RW] = ($urandom_range(0, 1) == 0) ? RW'($urandom_range(0, 3)) : RW'($urandom);
         i = rnd128();
         clr_req = ($urandom_range(0, 99) == 0);
         clr_thread = TW'($urandom);
         cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
